// File: rtl/rgb2ycc_pkg.sv
// rgb2ycc_pkg: shared constants for the RGB -> YCbCr converter.
// Coefficients are signed 9-bit values with 8 fraction bits (scale 256),
// indexed [mode][channel][component] with channel 0/1/2 = Y/Cb/Cr and
// component 0/1/2 = R/G/B.
package rgb2ycc_pkg;

    typedef enum logic {
        MODE_601 = 1'b0,
        MODE_709 = 1'b1
    } mode_e;

    localparam int FRAC   = 8;
    localparam int ROUND  = 128;
    localparam int COEF_W = 9;

    localparam logic signed [COEF_W-1:0] COEF [2][3][3] = '{
        // BT.601 full range
        '{
            '{ 9'sd77,  9'sd150,  9'sd29  },
            '{-9'sd43, -9'sd85,   9'sd128 },
            '{ 9'sd128, -9'sd107, -9'sd21 }
        },
        // BT.709 full range
        '{
            '{ 9'sd54,  9'sd183,  9'sd19  },
            '{-9'sd29, -9'sd99,   9'sd128 },
            '{ 9'sd128, -9'sd116, -9'sd12 }
        }
    };

endpackage

// File: rtl/rgb2ycc_if.sv
// rgb2ycc_if: pixel-in / pixel-out valid-ready bundle for rgb2ycc_pipe.
// The master side is the pixel source and the downstream sink; the slave
// side is the converter itself.
interface rgb2ycc_if #(
    parameter int CW = 8
);
    logic            rgb__valid;
    logic            rgb__ready;
    logic [3*CW-1:0] rgb;
    logic            mode;
    logic            ycc__valid;
    logic            ycc__ready;
    logic [3*CW-1:0] ycc;

    modport master (
        output rgb__valid,
        output rgb,
        output mode,
        output ycc__ready,
        input  rgb__ready,
        input  ycc__valid,
        input  ycc
    );

    modport slave (
        input  rgb__valid,
        input  rgb,
        input  mode,
        input  ycc__ready,
        output rgb__ready,
        output ycc__valid,
        output ycc
    );

endinterface

// File: rtl/rgb2ycc_fifo.sv
// rgb2ycc_fifo: 4-entry output FIFO with registered full/empty flags.
// A push while full is only taken when a pop happens in the same cycle;
// the 2-bit pointers wrap naturally modulo 4.
module rgb2ycc_fifo #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 4;

    logic [W-1:0] mem [DEPTH];
    logic [1:0]   wr_ptr;
    logic [1:0]   rd_ptr;
    logic [2:0]   count;
    logic [2:0]   count_nxt;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Occupancy after this cycle's push/pop, used to register the flags.
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 3'd1;
            2'b01:   count_nxt = count - 3'd1;
            default: count_nxt = count;
        endcase
    end

    // Storage, pointers and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count_nxt;
            full  <= (count_nxt == 3'd4);
            empty <= (count_nxt == 3'd0);
        end
    end

endmodule

// File: rtl/rgb2ycc_pipe.sv
// rgb2ycc_pipe: fully pipelined RGB -> YCbCr converter, BT.601 or BT.709
// selected per pixel by the mode bit that travels with the pixel.
// Stage 1 registers the nine products, stage 2 the three rounded sums,
// stage 3 the shifted, offset and clamped components.
// Build macro RGB2YCC_SKID_EN: free-running pipeline feeding a 4-entry
// output FIFO guarded by a credit counter, so rgb__ready is a register
// with no combinational path from ycc__ready. Without it the whole
// pipeline stalls on back-pressure and rgb__ready is combinational.
import rgb2ycc_pkg::*;

module rgb2ycc_pipe #(
    parameter int CW = 8
) (
    input logic      clk,
    input logic      rst,
    rgb2ycc_if.slave bus
);
    localparam int AW = CW + 11;

    logic                 en;
    logic                 accept;
    logic [CW-1:0]        comp_in [3];
    logic signed [AW-1:0] prod_d  [3][3];

    logic                 s1_valid;
    logic signed [AW-1:0] s1_prod [3][3];

    logic                 s2_valid;
    logic signed [AW-1:0] s2_acc  [3];

    logic [CW-1:0]        chan_res [3];
    logic                 s3_valid;
    logic [3*CW-1:0]      s3_data;

    assign accept     = bus.rgb__valid & bus.rgb__ready;
    assign comp_in[0] = bus.rgb[3*CW-1 -: CW];
    assign comp_in[1] = bus.rgb[2*CW-1 -: CW];
    assign comp_in[2] = bus.rgb[CW-1:0];

    // Nine signed products for the incoming pixel using its own mode.
    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            for (int c = 0; c < 3; c++) begin
                prod_d[ch][c] = AW'(COEF[bus.mode][ch][c]) * $signed(AW'(comp_in[c]));
            end
        end
    end

    // Stage 1: capture the products of an accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                for (int c = 0; c < 3; c++) begin
                    s1_prod[ch][c] <= '0;
                end
            end
        end else if (en) begin
            s1_valid <= accept;
            s1_prod  <= prod_d;
        end
    end

    // Stage 2: per-channel sum with the rounding constant folded in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                s2_acc[ch] <= '0;
            end
        end else if (en) begin
            s2_valid <= s1_valid;
            for (int ch = 0; ch < 3; ch++) begin
                s2_acc[ch] <= s1_prod[ch][0] + s1_prod[ch][1] + s1_prod[ch][2] + AW'(ROUND);
            end
        end
    end

    // Arithmetic shift, chroma offset and clamp to the component range.
    for (genvar ch = 0; ch < 3; ch++) begin : g_out
        localparam logic signed [AW-1:0] OFFSET = AW'((ch == 0) ? 0 : (1 << (CW - 1)));

        logic signed [AW-1:0] shifted;
        logic signed [AW-1:0] biased;

        assign shifted      = s2_acc[ch] >>> FRAC;
        assign biased       = shifted + OFFSET;
        assign chan_res[ch] = biased[AW-1]        ? '0 :
                              (|biased[AW-2:CW])  ? '1 :
                              biased[CW-1:0];
    end

    // Stage 3: final packed {Y, Cb, Cr} result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_data  <= '0;
        end else if (en) begin
            s3_valid <= s2_valid;
            s3_data  <= {chan_res[0], chan_res[1], chan_res[2]};
        end
    end

`ifdef RGB2YCC_SKID_EN

    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic [2:0] credit;
    logic [2:0] credit_nxt;
    logic       rdy_q;

    assign en             = 1'b1;
    assign pop            = bus.ycc__ready & ~fifo_empty;
    assign bus.ycc__valid = ~fifo_empty;
    assign bus.rgb__ready = rdy_q & ~rst;

    rgb2ycc_fifo #(
        .W(3*CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s3_valid),
        .wdata (s3_data),
        .pop   (pop),
        .rdata (bus.ycc),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Outstanding-pixel count: up on accept, down on pop, unchanged on both.
    always_comb begin
        credit_nxt = credit;
        if (accept && !pop) begin
            credit_nxt = credit + 3'd1;
        end else if (!accept && pop) begin
            credit_nxt = credit - 3'd1;
        end
    end

    // Credit register and registered input ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= '0;
            rdy_q  <= 1'b1;
        end else begin
            credit <= credit_nxt;
            rdy_q  <= (credit_nxt < 3'd4);
        end
    end

    // With at most four pixels outstanding, a full FIFO means the pipeline is empty.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(s3_valid && fifo_full && !pop));

`else

    assign en             = ~s3_valid | bus.ycc__ready;
    assign bus.rgb__ready = en & ~rst;
    assign bus.ycc__valid = s3_valid;
    assign bus.ycc        = s3_data;

`endif

endmodule

// File: tb/tb_rgb2ycc_pipe.sv
// tb_rgb2ycc_pipe: directed vector table plus streaming, stall, reset and
// random sequences for rgb2ycc_pipe at CW = 8.
// Honours RGB2YCC_SKID_EN for latency and outstanding-pixel expectations.
module tb_rgb2ycc_pipe;

`ifdef RGB2YCC_SKID_EN
    localparam int LAT    = 4;
    localparam int MAXOUT = 4;
`else
    localparam int LAT    = 3;
    localparam int MAXOUT = 3;
`endif

    typedef struct {
        logic [23:0] rgb;
        logic        mode;
        logic [23:0] ycc;
        string       name;
    } vec_t;

    logic clk;
    logic rst;

    rgb2ycc_if #(.CW(8)) bus ();

    rgb2ycc_pipe #(.CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          rand_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [23:0] prev_ycc = '0;
    logic [23:0] exp_q [$];
    int          xfer_cyc [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent integer model of the conversion.
    function automatic logic [23:0] refModel(input logic [23:0] px, input logic m);
        int         k [3][3];
        int         comp [3];
        int         acc;
        logic [7:0] o [3];
        if (m) k = '{'{54, 183, 19}, '{-29, -99, 128}, '{128, -116, -12}};
        else   k = '{'{77, 150, 29}, '{-43, -85, 128}, '{128, -107, -21}};
        comp[0] = int'(px[23:16]);
        comp[1] = int'(px[15:8]);
        comp[2] = int'(px[7:0]);
        for (int ch = 0; ch < 3; ch++) begin
            acc = k[ch][0] * comp[0] + k[ch][1] * comp[1] + k[ch][2] * comp[2] + 128;
            acc = acc >>> 8;
            if (ch != 0) acc += 128;
            if (acc < 0)        o[ch] = 8'd0;
            else if (acc > 255) o[ch] = 8'd255;
            else                o[ch] = acc[7:0];
        end
        return {o[0], o[1], o[2]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one pixel at a negedge and hold it until accepted.
    task automatic applyStimulus(input logic [23:0] px, input logic m, output int waits);
        waits = 0;
        bus.rgb        = px;
        bus.mode       = m;
        bus.rgb__valid = 1'b1;
        #1;
        while (!bus.rgb__ready && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!bus.rgb__ready) begin
            checkOutput("accept_timeout", 32'(bus.rgb__ready), 32'd1);
        end else begin
            exp_q.push_back(refModel(px, m));
        end
        @(negedge clk);
        bus.rgb__valid = 1'b0;
    endtask

    task automatic drainOutputs(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        checkOutput(name, exp_q.size(), 0);
    endtask

    // Output scoreboard and stall-stability monitor.
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (mon_en && !rst) begin
            if (prev_stall && bus.ycc__valid) begin
                checkOutput("stall_hold", 32'(bus.ycc), 32'(prev_ycc));
            end
            if (bus.ycc__valid && bus.ycc__ready) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got ycc=%0h, expected no output", bus.ycc);
                end else begin
                    checkOutput("stream_data", 32'(bus.ycc), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = bus.ycc__valid && !bus.ycc__ready;
            prev_ycc   = bus.ycc;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Random downstream back-pressure during the random phase.
    always begin
        @(negedge clk);
        if (rand_ready) bus.ycc__ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        tbl [10];
        int          lat;
        int          waits;
        int          total_waits;
        int          base;
        int          span;
        int          outstanding;
        logic [23:0] px;

        tbl[0] = '{24'hFFFFFF, 1'b0, {8'd255, 8'd128, 8'd128}, "601_white"};
        tbl[1] = '{24'h000000, 1'b0, {8'd0,   8'd128, 8'd128}, "601_black"};
        tbl[2] = '{24'hFF0000, 1'b0, {8'd77,  8'd85,  8'd255}, "601_red"};
        tbl[3] = '{24'hFF0000, 1'b1, {8'd54,  8'd99,  8'd255}, "709_red"};
        tbl[4] = '{24'h0000FF, 1'b0, {8'd29,  8'd255, 8'd107}, "601_blue"};
        tbl[5] = '{24'h00FF00, 1'b0, {8'd149, 8'd43,  8'd21},  "601_green"};
        tbl[6] = '{24'h00FF00, 1'b1, {8'd182, 8'd29,  8'd12},  "709_green"};
        tbl[7] = '{24'hFFFFFF, 1'b1, {8'd255, 8'd128, 8'd128}, "709_white"};
        tbl[8] = '{24'h0000FF, 1'b1, {8'd19,  8'd255, 8'd116}, "709_blue"};
        tbl[9] = '{{8'd100, 8'd50, 8'd200}, 1'b0, {8'd82, 8'd195, 8'd141}, "601_mixed"};

        rst            = 1'b1;
        bus.rgb__valid = 1'b0;
        bus.rgb        = '0;
        bus.mode       = 1'b0;
        bus.ycc__ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_ycc_valid", 32'(bus.ycc__valid), 32'd0);
        checkOutput("reset_ycc", 32'(bus.ycc), 32'd0);
        checkOutput("reset_rgb_ready", 32'(bus.rgb__ready), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("idle_rgb_ready", 32'(bus.rgb__ready), 32'd1);
        @(negedge clk);

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].rgb, tbl[i].mode, waits);
            lat = 1;
            while (!bus.ycc__valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checkOutput({tbl[i].name, "_latency"}, lat, LAT);
            checkOutput(tbl[i].name, 32'(bus.ycc), 32'(tbl[i].ycc));
            exp_q.delete();
            repeat (2) @(negedge clk);
        end

        $display("[TB] alternating mode, back-to-back");
        mon_en      = 1'b1;
        total_waits = 0;
        xfer_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(24'($urandom), i[0], waits);
            total_waits += waits;
        end
        drainOutputs("b2b_drain");
        checkOutput("b2b_no_wait", total_waits, 0);
        checkOutput("b2b_count", xfer_cyc.size(), 16);
        span = (xfer_cyc.size() >= 16) ? (xfer_cyc[15] - xfer_cyc[0]) : -1;
        checkOutput("b2b_span", span, 15);

        $display("[TB] ten-cycle downstream stall");
        xfer_cyc.delete();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    applyStimulus(24'($urandom), 1'($urandom), waits);
                end
            end
            begin
                repeat (3) @(negedge clk);
                bus.ycc__ready = 1'b0;
                repeat (10) @(negedge clk);
                bus.ycc__ready = 1'b1;
            end
        join
        drainOutputs("stall_drain");
        checkOutput("stall_count", xfer_cyc.size(), 20);

        $display("[TB] outstanding limit");
        bus.ycc__ready = 1'b0;
        outstanding    = 0;
        px             = 24'($urandom);
        bus.rgb        = px;
        bus.mode       = 1'b1;
        bus.rgb__valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bus.rgb__ready) begin
                outstanding++;
                exp_q.push_back(refModel(px, bus.mode));
                px = 24'($urandom);
            end
            @(negedge clk);
            bus.rgb = px;
        end
        bus.rgb__valid = 1'b0;
        checkOutput("outstanding_limit", outstanding, MAXOUT);
        bus.ycc__ready = 1'b1;
        drainOutputs("outstanding_drain");

        $display("[TB] reset with pixels in flight");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(24'($urandom), 1'($urandom), waits);
        end
        rst = 1'b1;
        #1;
        checkOutput("midrst_ycc_valid", 32'(bus.ycc__valid), 32'd0);
        checkOutput("midrst_ycc", 32'(bus.ycc), 32'd0);
        checkOutput("midrst_rgb_ready", 32'(bus.rgb__ready), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        base = xfer_cyc.size();
        repeat (10) @(negedge clk);
        checkOutput("post_rst_silent", xfer_cyc.size() - base, 0);
        applyStimulus(tbl[9].rgb, tbl[9].mode, waits);
        lat = 1;
        while (!bus.ycc__valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("post_rst_latency", lat, LAT);
        checkOutput("post_rst_first", 32'(bus.ycc), 32'(tbl[9].ycc));
        drainOutputs("post_rst_drain");

        $display("[TB] random stream");
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(24'($urandom), 1'($urandom), waits);
        end
        rand_ready     = 1'b0;
        bus.ycc__ready = 1'b1;
        drainOutputs("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
